nibble_serial_sub: RTL and testbench
====================================

# nibble_serial_sub

Nibble-serial unsigned subtractor computing `diff = a - b mod 2^WIDTH` plus a borrow flag. It processes one 4-bit slice per clock through a single 4-bit carry-lookahead slice, with the borrow chained in a register between slices. It is the inverse-direction companion to the 4-bit exact adder in the arithmetic model library. Reference workloads use it where area matters more than latency, and accuracy experiments use it to recover operand differences from adder outputs. Operands enter and results leave over valid/ready handshakes.

## Interface
- `WIDTH`, default 16: operand and result width in bits. Must be a multiple of 4 and at least 4. `NIB = WIDTH/4`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operands `a`, `b` are valid.
- `in_ready` output 1: block can accept operands.
- `a` input WIDTH: minuend, unsigned.
- `b` input WIDTH: subtrahend, unsigned.
- `out_valid` output 1: `diff` and `borrow` are valid.
- `out_ready` input 1: consumer accepts the result.
- `diff` output WIDTH: `(a - b) mod 2^WIDTH`.
- `borrow` output 1: set to 1 iff `a < b` (unsigned).

## Operation
- State machine has three states:
  - IDLE: `in_ready` = 1. On `in_valid && in_ready`, latch `a`, `b`, set nibble index k = 0 and carry = 1, then go to RUN.
  - RUN: each cycle computes slice k = `a[4k+3:4k] + ~b[4k+3:4k] + carry`. The 4 sum bits go into `diff[4k+3:4k]` and the carry-out goes into the carry register, then k increments. After slice NIB-1, set `borrow` = ~carry_out and go to DONE.
  - DONE: `out_valid` = 1. On `out_ready`, go to IDLE.
- `in_ready` is high only in IDLE and never while `rst` is high. No input is accepted in RUN or DONE.
- `diff` and `borrow` are result registers:
  - They hold stable throughout DONE.
  - They keep the last result in IDLE.
  - Nibbles of `diff` are overwritten during RUN; consumers sample only while `out_valid` is high.
- `in_valid` may drop or operands may change after acceptance without affecting the result, because operands are captured.
- `out_ready` is ignored outside DONE.
- Arithmetic is two's-complement subtraction via an inverted subtrahend with carry-in 1. Borrow is the inverted final carry. No signed interpretation and no saturation.

## Timing
- Reset values: state IDLE, `in_ready` 0 while `rst` is high and 1 on the first cycle after; `out_valid` 0, `diff` 0, `borrow` 0, k 0, carry 1.
- Reset is honoured in any state, including mid-RUN and in DONE with `out_valid` high. The in-flight operation is discarded with no result emitted.
- Latency: with acceptance at edge T0, slices complete at edges T1..T(NIB), and `out_valid` is high from the cycle after T(NIB). That is NIB cycles after acceptance; 4 for WIDTH=16.
- Minimum initiation interval is NIB+2 cycles:
  - DONE with `out_ready` high → IDLE at the next edge.
  - Earliest next acceptance is the edge after that.
- Backpressure: DONE persists indefinitely while `out_ready` is low, with outputs frozen.
- All outputs are registered. `in_ready` and `out_valid` are decoded from registered state only; there is no combinational path from `in_valid` or `out_ready`.

## Structure
- Shared package `approx_arith_pkg` holds:
  - constant `NIBBLE_W = 4`;
  - enum `sub_state_t` {IDLE, RUN, DONE};
  - a localparam helper for the nibble-index width, `$clog2(NIB)` with a minimum of 1.
- One sub-module, `sub4_slice`: combinational 4-bit slice with inputs `x[3:0]`, `y[3:0]`, `cin` and outputs `s[3:0]`, `cout`. It is built as a generate/propagate carry-lookahead on `x` and `~y`, so the same slice can be swapped for approximate variants in experiments.
- Top level contains the FSM, operand registers, nibble index, carry register and result registers.

## Test plan
- WIDTH=16, `a`=0x1234, `b`=0x0234 → `diff`=0x1000, `borrow`=0; `out_valid` rises exactly 4 cycles after acceptance.
- `a`=0x0000, `b`=0x0001 → `diff`=0xFFFF, `borrow`=1. `a`=0x1000, `b`=0x0001 → `diff`=0x0FFF, `borrow`=0; the borrow ripples across all nibbles.
- `a`=`b`=0xABCD → `diff`=0x0000, `borrow`=0. `a`=0x8000, `b`=0x7FFF → `diff`=0x0001, `borrow`=0.
- Hold `out_ready` low for 5 cycles in DONE → `diff` and `borrow` stable, `in_ready` low, `in_valid` pulses ignored. Raise `out_ready` → IDLE next cycle, and the next acceptance is no earlier than NIB+2 cycles after the previous one.
- Assert `rst` for one cycle during RUN at k=2 → next cycle IDLE, `out_valid`=0, `diff`=0. A fresh 0x0005 - 0x0003 → `diff`=0x0002, `borrow`=0.
- WIDTH=4 instance, `a`=0x3, `b`=0x5 → `diff`=0xE, `borrow`=1, 1-cycle latency. Random back-to-back transactions are checked against a reference model.

Source files
------------

// File: rtl/approx_arith_pkg.sv
// Shared types and constants for the nibble-serial arithmetic blocks.
package approx_arith_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Width of the nibble index; never narrower than one bit.
    function automatic int nib_idx_w(input int nib);
        if (nib > 1) begin
            return $clog2(nib);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/sub4_slice.sv
// Combinational 4-bit subtract slice: x + ~y + cin using generate/propagate lookahead.
module sub4_slice
    import approx_arith_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] yn_s;
    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [4:0] c_s;

    // Lookahead carries, each written directly from g/p and cin rather than rippled.
    always_comb begin
        yn_s   = ~y;
        g_s    = x & yn_s;
        p_s    = x ^ yn_s;
        c_s[0] = cin;
        c_s[1] = g_s[0] | (p_s[0] & cin);
        c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
        c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
               | (p_s[2] & p_s[1] & p_s[0] & cin);
        c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
               | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
               | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);
        s      = p_s ^ c_s[3:0];
        cout   = c_s[4];
    end

endmodule

// File: rtl/nibble_serial_sub.sv
// Nibble-serial unsigned subtractor: one 4-bit slice per clock, borrow chained through a carry register.
module nibble_serial_sub
    import approx_arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int KW  = nib_idx_w(NIB);
    localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

    sub_state_t       state_r;
    sub_state_t       next_state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [KW-1:0]    k_r;
    logic             carry_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_r;
    logic             out_valid_r;
    logic             in_ready_r;
    logic [3:0]       x_s;
    logic [3:0]       y_s;
    logic [3:0]       sum_s;
    logic             cout_s;

    // Select the operand nibbles for the slice currently being processed.
    always_comb begin
        x_s = a_r[NIBBLE_W*int'(k_r) +: NIBBLE_W];
        y_s = b_r[NIBBLE_W*int'(k_r) +: NIBBLE_W];
    end

    sub4_slice u_slice (
        .x    (x_s),
        .y    (y_s),
        .cin  (carry_r),
        .s    (sum_s),
        .cout (cout_s)
    );

    // Next-state decode; handshake inputs only steer the state, never the outputs directly.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (k_r == K_LAST) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State, datapath and result registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            k_r         <= '0;
            carry_r     <= 1'b1;
            diff_r      <= '0;
            borrow_r    <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            out_valid_r <= (next_state_s == DONE);
            in_ready_r  <= (next_state_s == IDLE);
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        k_r     <= '0;
                        carry_r <= 1'b1;
                    end
                end
                RUN: begin
                    diff_r[NIBBLE_W*int'(k_r) +: NIBBLE_W] <= sum_s;
                    carry_r <= cout_s;
                    k_r     <= k_r + {{(KW-1){1'b0}}, 1'b1};
                    if (k_r == K_LAST) begin
                        borrow_r <= ~cout_s;
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

    // The ready flag is also masked by reset so no handshake can complete while reset is held.
    assign in_ready  = in_ready_r & ~rst;
    assign out_valid = out_valid_r;
    assign diff      = diff_r;
    assign borrow    = borrow_r;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Self-checking bench for nibble_serial_sub: directed cases plus random traffic against an arithmetic model.
module tb_nibble_serial_sub;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b0, bo16;
    logic [15:0] a16 = 16'h0, b16 = 16'h0, d16;
    logic        iv4 = 1'b0, ir4, ov4, or4 = 1'b0, bo4;
    logic [3:0]  a4 = 4'h0, b4 = 4'h0, d4;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int last_acc16 = -1;
    int last_acc4  = -1;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_sub #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .out_valid(ov16), .out_ready(or16), .diff(d16), .borrow(bo16)
    );

    nibble_serial_sub #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .out_valid(ov4), .out_ready(or4), .diff(d4), .borrow(bo4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction on the 16-bit (w4=0) or 4-bit (w4=1) instance, with `hold` cycles of backpressure.
    task automatic txn(input bit w4, input logic [15:0] a, input logic [15:0] b, input int hold);
        int          nib;
        int          n;
        int          t;
        logic [15:0] mask;
        logic [15:0] exp_d;
        logic        exp_b;
        logic [15:0] obs_d;
        logic        obs_b;
        nib   = w4 ? 1 : 4;
        mask  = w4 ? 16'h000F : 16'hFFFF;
        exp_d = (a - b) & mask;
        exp_b = ((a & mask) < (b & mask)) ? 1'b1 : 1'b0;

        @(negedge clk);
        if (w4) begin a4 = a[3:0]; b4 = b[3:0]; iv4 = 1'b1; end
        else    begin a16 = a;     b16 = b;     iv16 = 1'b1; end
        n = 0;
        while (!(w4 ? ir4 : ir16) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(n < 50), 32'd1);

        @(posedge clk);
        #1;
        t = cyc;
        if (w4) begin
            if (last_acc4 >= 0) chk("init_interval", 32'((t - last_acc4) >= nib + 2), 32'd1);
            last_acc4 = t;
            iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        end else begin
            if (last_acc16 >= 0) chk("init_interval", 32'((t - last_acc16) >= nib + 2), 32'd1);
            last_acc16 = t;
            iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        end

        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(w4 ? ov4 : ov16) && n < 50);
        chk("latency", 32'(n), 32'(nib));

        obs_d = w4 ? {12'h000, d4} : d16;
        obs_b = w4 ? bo4 : bo16;
        chk("diff", 32'(obs_d), 32'(exp_d));
        chk("borrow", 32'(obs_b), 32'(exp_b));

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (w4) iv4 = 1'b1; else iv16 = 1'b1;
            chk("ready_in_done", 32'(w4 ? ir4 : ir16), 32'd0);
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(w4 ? ov4 : ov16), 32'd1);
            chk("hold_diff", 32'(w4 ? {12'h000, d4} : d16), 32'(exp_d));
            chk("hold_borrow", 32'(w4 ? bo4 : bo16), 32'(exp_b));
        end

        @(negedge clk);
        if (w4) begin iv4 = 1'b0; or4 = 1'b1; end
        else    begin iv16 = 1'b0; or16 = 1'b1; end
        @(posedge clk);
        #1;
        if (w4) or4 = 1'b0; else or16 = 1'b0;
        chk("idle_valid", 32'(w4 ? ov4 : ov16), 32'd0);
        chk("idle_ready", 32'(w4 ? ir4 : ir16), 32'd1);
        chk("idle_keep_diff", 32'(w4 ? {12'h000, d4} : d16), 32'(exp_d));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(ir16), 32'd0);
        chk("rst_out_valid", 32'(ov16), 32'd0);
        chk("rst_diff", 32'(d16), 32'd0);
        chk("rst_borrow", 32'(bo16), 32'd0);
        chk("rst_in_ready_w4", 32'(ir4), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(ir16), 32'd1);

        txn(1'b0, 16'h1234, 16'h0234, 0);
        txn(1'b0, 16'h0000, 16'h0001, 0);
        txn(1'b0, 16'h1000, 16'h0001, 0);
        txn(1'b0, 16'hABCD, 16'hABCD, 0);
        txn(1'b0, 16'h8000, 16'h7FFF, 5);
        txn(1'b0, 16'hFFFF, 16'h0000, 0);

        // Reset while the third slice (k=2) is being processed.
        @(negedge clk);
        a16 = 16'hF0F0; b16 = 16'h0F0F; iv16 = 1'b1;
        @(posedge clk);
        #1;
        iv16 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ready_during_rst", 32'(ir16), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrun_rst_valid", 32'(ov16), 32'd0);
        chk("midrun_rst_diff", 32'(d16), 32'd0);
        chk("midrun_rst_borrow", 32'(bo16), 32'd0);
        @(posedge clk);
        #1;
        chk("midrun_rst_idle", 32'(ir16), 32'd1);
        chk("midrun_rst_no_result", 32'(ov16), 32'd0);
        last_acc16 = -1;
        last_acc4  = -1;
        txn(1'b0, 16'h0005, 16'h0003, 0);

        txn(1'b1, 16'h0003, 16'h0005, 0);
        txn(1'b1, 16'h0007, 16'h0007, 2);

        for (int i = 0; i < 20; i++) begin
            txn(1'b0, 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
            txn(1'b1, 16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
